// File: rtl/mem_sequencer_pkg.sv
// Shared types and defaults for the kernel/weight memory sequencer.
package mem_sequencer_pkg;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEARN,
    ST_CLASSIFY,
    ST_DRAIN
  } state_t;
endpackage

// File: rtl/mem_sequencer_addr_cnt.sv
// Shared memory address counter; saturates at DEPTH-1 and flags the last word.
module seq_addr_cnt
  import mem_sequencer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);

  assign last = (cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_sequencer.sv
// Sequences learn-phase writes and classify-phase reads over a kernel and a
// weight SRAM that share one address; all memory pins are registered.
module mem_sequencer
  import mem_sequencer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              learn,
  input  logic              classify,
  input  logic [31:0]       wr_kdata,
  input  logic [31:0]       wr_wdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] KMEM_ADD,
  output logic [ADDR_W-1:0] WMEM_ADD,
  output logic              KMEM_CSB,
  output logic              KMEM_WEB,
  output logic              KMEM_OEB,
  output logic              WMEM_CSB,
  output logic              WMEM_WEB,
  output logic              WMEM_OEB,
  output logic [31:0]       KMEM_DI,
  output logic [31:0]       WMEM_DI,
  input  logic [31:0]       KMEM_DO,
  input  logic [31:0]       WMEM_DO,
  output logic [31:0]       rd_kdata,
  output logic [31:0]       rd_wdata,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_last;
  logic              cnt_clr;
  logic              cnt_en;
  logic              beat;

  // Both memories always see the same address and strobes.
  logic [ADDR_W-1:0] pin_add;
  word_t             pin_kdi;
  word_t             pin_wdi;
  logic              pin_csb;
  logic              pin_web;
  logic              pin_oeb;

  assign KMEM_ADD = pin_add;
  assign WMEM_ADD = pin_add;
  assign KMEM_DI  = pin_kdi;
  assign WMEM_DI  = pin_wdi;
  assign KMEM_CSB = pin_csb;
  assign WMEM_CSB = pin_csb;
  assign KMEM_WEB = pin_web;
  assign WMEM_WEB = pin_web;
  assign KMEM_OEB = pin_oeb;
  assign WMEM_OEB = pin_oeb;

  assign rd_kdata = rd_valid ? KMEM_DO : '0;
  assign rd_wdata = rd_valid ? WMEM_DO : '0;

  assign beat = (state == ST_LEARN) && wr_valid && wr_ready;

  seq_addr_cnt #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .last(cnt_last)
  );

  // In LEARN the counter is the next write address; in CLASSIFY it tracks the
  // address currently on the pins.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state)
      ST_IDLE:     cnt_clr = 1'b1;
      ST_LEARN: begin
        if (beat) begin
          cnt_clr = cnt_last;
          cnt_en  = !cnt_last;
        end
      end
      ST_CLASSIFY: begin
        cnt_clr = cnt_last;
        cnt_en  = !cnt_last;
      end
      ST_DRAIN:    cnt_clr = 1'b1;
      default:     cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pin_add  <= '0;
      pin_kdi  <= '0;
      pin_wdi  <= '0;
      pin_csb  <= 1'b1;
      pin_web  <= 1'b1;
      pin_oeb  <= 1'b1;
    end else begin
      done     <= 1'b0;
      rd_valid <= (state == ST_CLASSIFY);
      pin_add  <= '0;
      pin_kdi  <= '0;
      pin_wdi  <= '0;
      pin_csb  <= 1'b1;
      pin_web  <= 1'b1;
      pin_oeb  <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (learn) begin
            state    <= ST_LEARN;
            wr_ready <= 1'b1;
            busy     <= 1'b1;
          end else if (classify) begin
            state   <= ST_CLASSIFY;
            busy    <= 1'b1;
            pin_csb <= 1'b0;
            pin_oeb <= 1'b0;
          end
        end
        ST_LEARN: begin
          if (beat) begin
            pin_add <= cnt;
            pin_kdi <= wr_kdata;
            pin_wdi <= wr_wdata;
            pin_csb <= 1'b0;
            pin_web <= 1'b0;
            // busy stays up through the final write cycle and drops in IDLE.
            if (cnt_last) begin
              state    <= ST_IDLE;
              wr_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        ST_CLASSIFY: begin
          if (cnt_last) begin
            state <= ST_DRAIN;
            done  <= 1'b1;
          end else begin
            pin_add <= cnt + 1'b1;
            pin_csb <= 1'b0;
            pin_oeb <= 1'b0;
          end
        end
        ST_DRAIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          wr_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a one-cycle-latency SRAM model.
module tb_mem_sequencer;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              learn, classify;
  logic [31:0]       wr_kdata, wr_wdata;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] KMEM_ADD, WMEM_ADD;
  logic              KMEM_CSB, KMEM_WEB, KMEM_OEB;
  logic              WMEM_CSB, WMEM_WEB, WMEM_OEB;
  logic [31:0]       KMEM_DI, WMEM_DI;
  logic [31:0]       KMEM_DO = '0;
  logic [31:0]       WMEM_DO = '0;
  logic [31:0]       rd_kdata, rd_wdata;
  logic              rd_valid, busy, done;

  logic [31:0] kmem [DEPTH];
  logic [31:0] wmem [DEPTH];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .learn(learn), .classify(classify),
    .wr_kdata(wr_kdata), .wr_wdata(wr_wdata), .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .KMEM_ADD(KMEM_ADD), .WMEM_ADD(WMEM_ADD),
    .KMEM_CSB(KMEM_CSB), .KMEM_WEB(KMEM_WEB), .KMEM_OEB(KMEM_OEB),
    .WMEM_CSB(WMEM_CSB), .WMEM_WEB(WMEM_WEB), .WMEM_OEB(WMEM_OEB),
    .KMEM_DI(KMEM_DI), .WMEM_DI(WMEM_DI),
    .KMEM_DO(KMEM_DO), .WMEM_DO(WMEM_DO),
    .rd_kdata(rd_kdata), .rd_wdata(rd_wdata), .rd_valid(rd_valid),
    .busy(busy), .done(done)
  );

  // Synchronous SRAMs: write on the edge closing the write cycle, read data
  // available the cycle after the address.
  always @(posedge clk) begin
    if (!KMEM_CSB && !KMEM_WEB) kmem[KMEM_ADD] <= KMEM_DI;
    if (!KMEM_CSB && !KMEM_OEB) KMEM_DO <= kmem[KMEM_ADD];
    if (!WMEM_CSB && !WMEM_WEB) wmem[WMEM_ADD] <= WMEM_DI;
    if (!WMEM_CSB && !WMEM_OEB) WMEM_DO <= wmem[WMEM_ADD];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_learn(input bit toggle, input bit with_classify,
                           input int exp_busy, input int limit);
    int nb = 0, wr_cnt = 0, busy_cyc = 0, done_cnt = 0;
    bit acc, rd_seen = 0;
    learn    = 1'b1;
    classify = with_classify;
    wr_valid = 1'b1;
    wr_kdata = 32'h100;
    wr_wdata = 32'h200;
    for (int cyc = 0; cyc < limit; cyc++) begin
      acc = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (acc) nb++;
      learn    = 1'b0;
      classify = (cyc == 5);
      wr_valid = toggle ? ~wr_valid : 1'b1;
      wr_kdata = 32'h100 + nb;
      wr_wdata = 32'h200 + nb;
      if (cyc == 0) check("learn_ready_first", {31'd0, wr_ready}, 1);
      check("learn_csb_vs_beat", {31'd0, KMEM_CSB}, {31'd0, !acc});
      if (busy) busy_cyc++;
      if (rd_valid) rd_seen = 1;
      if (!KMEM_CSB && !KMEM_WEB) begin
        check("learn_addr", {27'd0, KMEM_ADD}, wr_cnt);
        check("learn_waddr", {27'd0, WMEM_ADD}, wr_cnt);
        check("learn_kdi", KMEM_DI, 32'h100 + wr_cnt);
        check("learn_wdi", WMEM_DI, 32'h200 + wr_cnt);
        check("learn_w_strobes", {29'd0, WMEM_CSB, WMEM_WEB, WMEM_OEB}, 32'b001);
        check("learn_oeb", {31'd0, KMEM_OEB}, 1);
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("learn_done_on_last", {26'd0, KMEM_CSB, KMEM_ADD}, DEPTH - 1);
      end
      if (!busy) break;
    end
    classify = 1'b0;
    check("learn_writes", wr_cnt, DEPTH);
    check("learn_done_count", done_cnt, 1);
    check("learn_busy_cycles", busy_cyc, exp_busy);
    check("learn_ready_end", {31'd0, wr_ready}, 0);
    check("learn_ended", {31'd0, busy}, 0);
    check("learn_classify_ignored", {31'd0, rd_seen}, 0);
  endtask

  task automatic run_classify(input int limit);
    int ra = 0, rv = 0, dn = 0;
    classify = 1'b1;
    for (int cyc = 0; cyc < limit; cyc++) begin
      @(posedge clk); #1;
      classify = 1'b0;
      if (cyc == 0) check("cls_first_issue", {25'd0, busy, KMEM_CSB, KMEM_ADD}, 32'h40);
      if (!KMEM_CSB) begin
        check("cls_strobes", {26'd0, KMEM_WEB, KMEM_OEB, WMEM_CSB, WMEM_WEB, WMEM_OEB, 1'b0},
              32'b10_0100);
        check("cls_addr", {27'd0, KMEM_ADD}, ra);
        check("cls_waddr", {27'd0, WMEM_ADD}, ra);
        ra++;
      end
      if (rd_valid) begin
        check("cls_gap", cyc, rv + 1);
        check("cls_kdata", rd_kdata, 32'h100 + rv);
        check("cls_wdata", rd_wdata, 32'h200 + rv);
        rv++;
      end else begin
        check("cls_idle_data", rd_kdata | rd_wdata, 0);
      end
      if (done) begin
        dn++;
        check("cls_done_on_last", {31'd0, rd_valid}, 1);
        check("cls_done_count_at", rv, DEPTH);
      end
      if (!busy) break;
    end
    check("cls_issued", ra, DEPTH);
    check("cls_valid_count", rv, DEPTH);
    check("cls_done_count", dn, 1);
    check("cls_ended", {31'd0, busy}, 0);
  endtask

  initial begin
    int n;
    rst      = 1'b0;
    learn    = 1'b0;
    classify = 1'b0;
    wr_valid = 1'b0;
    wr_kdata = '0;
    wr_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {26'd0, KMEM_CSB, KMEM_WEB, KMEM_OEB, WMEM_CSB, WMEM_WEB, WMEM_OEB},
          32'h3F);
    check("rst_addr", {22'd0, KMEM_ADD, WMEM_ADD}, 0);
    check("rst_di", KMEM_DI | WMEM_DI, 0);
    check("rst_ctrl", {28'd0, wr_ready, rd_valid, busy, done}, 0);
    check("rst_rdata", rd_kdata | rd_wdata, 0);

    rst = 1'b1;
    run_learn(1'b0, 1'b1, 33, 80);
    run_classify(80);
    run_learn(1'b1, 1'b0, 65, 140);
    run_classify(80);

    // Abort a classify while address 10 is on the pins.
    classify = 1'b1;
    n = 0;
    @(posedge clk); #1;
    classify = 1'b0;
    while (!(!KMEM_CSB && KMEM_ADD == 5'd10) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_addr10", {31'd0, n < 40}, 1);
    rst = 1'b0;
    #1;
    check("abort_pins", {29'd0, KMEM_CSB, KMEM_OEB, WMEM_CSB}, 32'b111);
    check("abort_ctrl", {29'd0, rd_valid, busy, done}, 0);
    @(posedge clk); #1;
    check("abort_held", {28'd0, KMEM_CSB, rd_valid, busy, done}, 32'b1000);
    rst = 1'b1;
    run_classify(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter DEPTH, default 32, number of words in each memory (1..32).
REQ-002 Parameter ADDR_W, default 5, memory address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 learn  in  1  level request to start the write (learn) phase.
REQ-006 classify  in  1  level request to start the read (classify) phase.
REQ-007 wr_kdata, wr_wdata  in  32 each  kernel word and weight word for one learn beat.
REQ-008 wr_valid  in  1; wr_ready  out  1  learn-beat handshake.
REQ-009 KMEM_ADD, WMEM_ADD  out  ADDR_W  memory addresses.
REQ-010 KMEM_CSB/WEB/OEB, WMEM_CSB/WEB/OEB  out  1 each  active-low chip select, write enable, output enable.
REQ-011 KMEM_DI, WMEM_DI  out  32  write data; KMEM_DO, WMEM_DO  in  32  read data.
REQ-012 rd_kdata, rd_wdata  out  32; rd_valid  out  1  classify read stream.
REQ-013 busy  out  1  high in any non-IDLE state; done  out  1  one-cycle completion pulse.

Function
REQ-014 States: IDLE, LEARN, CLASSIFY, DRAIN; one-hot or binary at implementer's choice.
REQ-015 IDLE->LEARN when learn=1; IDLE->CLASSIFY when classify=1 and learn=0; learn wins if both high.
REQ-016 learn/classify outside IDLE are ignored; no queuing of requests.
REQ-017 LEARN: wr_ready=1; each accepted beat (wr_valid&wr_ready) writes wr_kdata to KMEM and wr_wdata to WMEM at shared address counter, counter starting at 0.
REQ-018 Memory pins registered: beat accepted at edge k drives ADD=counter, DI=data, CSB=0, WEB=0, OEB=1 during cycle k..k+1 only.
REQ-019 wr_valid=0 in LEARN: no write, counter holds, CSB=1.
REQ-020 After beat at address DEPTH-1 is accepted: wr_ready=0 next cycle, LEARN->IDLE, done pulses once while the final write is on the pins; counter never wraps.
REQ-021 CLASSIFY: one read issued per cycle, addresses 0..DEPTH-1 ascending, CSB=0, OEB=0, WEB=1 on both memories.
REQ-022 Memory read latency one cycle: rd_valid=1 the cycle after each address is on the pins; rd_kdata/rd_wdata pass KMEM_DO/WMEM_DO through in that cycle, 0 otherwise.
REQ-023 After address DEPTH-1 issued: CLASSIFY->DRAIN; DRAIN lasts one cycle for last rd_valid, done pulses in that cycle, then IDLE.
REQ-024 Exactly DEPTH rd_valid pulses per classify, no gaps; consumer provides no backpressure.
REQ-025 Idle pin values: ADD=0, DI=0, CSB=WEB=OEB=1.

Reset
REQ-026 rst=0 forces IDLE, counter=0, all outputs to REQ-025 values, wr_ready=rd_valid=busy=done=0, rd data 0.
REQ-027 Reset mid-LEARN or mid-CLASSIFY aborts immediately with no further memory access; data already written is not restored.
REQ-028 First request after rst release honoured on the first rising edge with rst=1.

Structure
REQ-029 Shared package holds state enum type, DEPTH/ADDR_W defaults, and 32-bit word typedef.
REQ-030 One sub-module, seq_addr_cnt: ADDR_W counter with clear, enable, and last (=DEPTH-1) flag.

Verification
REQ-031 Reset then learn=1 with wr_valid=1 continuous, DEPTH=32 -> 32 writes addresses 0..31, done once, busy 33 cycles total.
REQ-032 Learn with wr_valid toggling every other cycle -> writes only on accepted beats, addresses contiguous, no wrap past 31.
REQ-033 After learn of kdata=addr+0x100, wdata=addr+0x200, classify=1 -> rd_valid 32 consecutive cycles, rd_kdata 0x100..0x11F, rd_wdata 0x200..0x21F, done on last.
REQ-034 learn=classify=1 simultaneously in IDLE -> LEARN entered; classify pulses during LEARN ignored.
REQ-035 rst=0 at address 10 of CLASSIFY -> same-cycle CSB=OEB=1, rd_valid=0, state IDLE; next classify restarts at address 0.
